// File: rtl/spi_rx_capture_if.sv
// Bus and handshake bundle for spi_rx_capture: the master modport is the environment, the slave modport is the capture block.
// Optional frame counter/first-word signals exist only when SPI_RX_FRAME_CNT_EN is defined.
interface spi_rx_capture_if #(
  parameter int DATA_W = 8
);
  logic              sck_in;
  logic              miso_in;
  logic              ss1_in;
  logic              ss2_in;
  logic              rx_ready;
  logic              clr_flags;
  logic [DATA_W-1:0] rx_data;
  logic              rx_src;
  logic              rx_valid;
  logic              busy;
  logic              overflow;
  logic              sel_err;
  logic              frame_abort;
`ifdef SPI_RX_FRAME_CNT_EN
  logic [15:0]       frame_cnt;
  logic              rx_first;

  modport master (
    output sck_in, miso_in, ss1_in, ss2_in, rx_ready, clr_flags,
    input  rx_data, rx_src, rx_valid, busy, overflow, sel_err, frame_abort, frame_cnt, rx_first
  );
  modport slave (
    input  sck_in, miso_in, ss1_in, ss2_in, rx_ready, clr_flags,
    output rx_data, rx_src, rx_valid, busy, overflow, sel_err, frame_abort, frame_cnt, rx_first
  );
`else
  modport master (
    output sck_in, miso_in, ss1_in, ss2_in, rx_ready, clr_flags,
    input  rx_data, rx_src, rx_valid, busy, overflow, sel_err, frame_abort
  );
  modport slave (
    input  sck_in, miso_in, ss1_in, ss2_in, rx_ready, clr_flags,
    output rx_data, rx_src, rx_valid, busy, overflow, sel_err, frame_abort
  );
`endif
endinterface

// File: rtl/spi_rx_capture.sv
// SPI bus observer: deserialises MISO into words tagged with the sending slave and queues them in a FWFT FIFO.
// Optional macro SPI_RX_FRAME_CNT_EN adds a 16-bit frame counter and a per-word first-of-frame flag.
module spi_rx_capture #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input logic             clk,
  input logic             rst,
  spi_rx_capture_if.slave bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int BIT_W = $clog2(DATA_W);

  typedef enum logic {IDLE, SHIFT} state_t;

  typedef struct packed {
`ifdef SPI_RX_FRAME_CNT_EN
    logic              first;
`endif
    logic              src;
    logic [DATA_W-1:0] data;
  } entry_t;

  state_t            state_q, state_d;
  logic              sck_d_q;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              src_q, src_d;
  logic              word_done_q, word_done_d;
  logic              abort_q, abort_d;
  logic              overflow_q, overflow_d;
  logic              sel_err_q, sel_err_d;
  entry_t            mem_q [FIFO_DEPTH];
  entry_t            mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              sck_rise, sel_both, sel_high;
  logic              pop, push_ok, ovf_set;
  entry_t            push_entry;
`ifdef SPI_RX_FRAME_CNT_EN
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic              first_q, first_d;
  logic              done_first_q, done_first_d;
`endif

  assign sck_rise = bus.sck_in & ~sck_d_q;
  assign sel_both = ~bus.ss1_in & ~bus.ss2_in;
  assign sel_high = src_q ? bus.ss2_in : bus.ss1_in;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin : ctrl_next
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    src_d       = src_q;
    word_done_d = 1'b0;
    abort_d     = 1'b0;
`ifdef SPI_RX_FRAME_CNT_EN
    frame_cnt_d  = frame_cnt_q;
    first_d      = first_q;
    done_first_d = done_first_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.ss1_in ^ bus.ss2_in) begin
          state_d   = SHIFT;
          src_d     = ~bus.ss2_in;
          bit_cnt_d = '0;
          shift_d   = '0;
`ifdef SPI_RX_FRAME_CNT_EN
          first_d   = 1'b1;
`endif
        end
      end
      SHIFT: begin
        if (sel_both) begin
          state_d = IDLE;
        end else if (sel_high) begin
          state_d = IDLE;
          abort_d = (bit_cnt_q != '0);
`ifdef SPI_RX_FRAME_CNT_EN
          frame_cnt_d = frame_cnt_q + 16'd1;
`endif
        end else if (sck_rise) begin
          shift_d = {shift_q[DATA_W-2:0], bus.miso_in};
          if (bit_cnt_q == BIT_W'(DATA_W - 1)) begin
            // Counter wraps so a held select keeps streaming further words.
            bit_cnt_d   = '0;
            word_done_d = 1'b1;
`ifdef SPI_RX_FRAME_CNT_EN
            done_first_d = first_q;
            first_d      = 1'b0;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The word completed last cycle sits in shift_q; the next sampling edge is at least two cycles away.
  always_comb begin : fifo_next
    push_entry      = '0;
    push_entry.data = shift_q;
    push_entry.src  = src_q;
`ifdef SPI_RX_FRAME_CNT_EN
    push_entry.first = done_first_q;
`endif
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    pop      = (count_q != '0) & bus.rx_ready;
    push_ok  = word_done_q & ((count_q != CNT_W'(FIFO_DEPTH)) | pop);
    ovf_set  = word_done_q & ~push_ok;
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_entry;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    count_d    = count_q + CNT_W'(push_ok) - CNT_W'(pop);
    // A set event in the same cycle as clr_flags wins.
    overflow_d = ovf_set  | (overflow_q & ~bus.clr_flags);
    sel_err_d  = sel_both | (sel_err_q  & ~bus.clr_flags);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sck_d_q     <= 1'b0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      src_q       <= 1'b0;
      word_done_q <= 1'b0;
      abort_q     <= 1'b0;
      overflow_q  <= 1'b0;
      sel_err_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      // NOTE: the storage is reset because the head entry is visible on rx_data, which must read 0 after reset.
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
`ifdef SPI_RX_FRAME_CNT_EN
      frame_cnt_q  <= '0;
      first_q      <= 1'b0;
      done_first_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sck_d_q     <= bus.sck_in;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      src_q       <= src_d;
      word_done_q <= word_done_d;
      abort_q     <= abort_d;
      overflow_q  <= overflow_d;
      sel_err_q   <= sel_err_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
`ifdef SPI_RX_FRAME_CNT_EN
      frame_cnt_q  <= frame_cnt_d;
      first_q      <= first_d;
      done_first_q <= done_first_d;
`endif
    end
  end

  assign bus.rx_data     = mem_q[rd_ptr_q].data;
  assign bus.rx_src      = mem_q[rd_ptr_q].src;
  assign bus.rx_valid    = (count_q != '0);
  assign bus.busy        = (state_q == SHIFT);
  assign bus.overflow    = overflow_q;
  assign bus.sel_err     = sel_err_q;
  assign bus.frame_abort = abort_q;
`ifdef SPI_RX_FRAME_CNT_EN
  assign bus.frame_cnt   = frame_cnt_q;
  assign bus.rx_first    = mem_q[rd_ptr_q].first;
`endif

endmodule
